// File: rtl/adder_tree_acc_ctrl.sv
// Accumulation controller for a 256-input adder tree: sums num_pass tree results
// onto a bias value and presents the total through a valid/ready output handshake.
module adder_tree_acc_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [CNT_W-1:0]        num_pass_i,
  input  logic signed [WIDTH-1:0] bias_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic signed [WIDTH-1:0] tree_sum_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic signed [WIDTH-1:0] acc_out_o,
  output logic                    busy_o,
  output logic                    done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]        num_pass_q, num_pass_d;
  logic                    accept;
  logic                    last_pass;

  assign accept    = in_valid_i && (state_q == ACCUM);
  assign last_pass = (pass_cnt_q == (num_pass_q - CNT_W'(1)));

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    pass_cnt_d = pass_cnt_q;
    num_pass_d = num_pass_q;
    unique case (state_q)
      IDLE: begin
        // A zero-length job is dropped so the output handshake never fires for it.
        if (start_i && (num_pass_i != '0)) begin
          num_pass_d = num_pass_i;
          acc_d      = bias_i;
          pass_cnt_d = '0;
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d      = acc_q + tree_sum_i;
          pass_cnt_d = pass_cnt_q + CNT_W'(1);
          if (last_pass) begin
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      pass_cnt_q <= '0;
      num_pass_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      pass_cnt_q <= pass_cnt_d;
      num_pass_q <= num_pass_d;
    end
  end

  assign in_ready_o  = (state_q == ACCUM);
  assign out_valid_o = (state_q == OUT);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == OUT) && out_ready_i;
  assign acc_out_o   = acc_q;

endmodule
